// File: rtl/ctrl_pipe_reg.sv
// Control-signal pipeline registers for ID/EX -> EX/MEM -> MEM/WB with hold, flush,
// valid gating and a saturating retirement counter.
module ctrl_pipe_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold_i,
    input  logic       flush_i,
    input  logic       valid_i,
    input  logic       shift_i,
    input  logic       size_i,
    input  logic       enable_i,
    input  logic       rw_i,
    input  logic       load_i,
    input  logic       s_i,
    input  logic       rf_i,
    input  logic [3:0] alu_i,
    input  logic [3:0] rd_i,
    output logic       valid_ex,
    output logic       shift_ex,
    output logic       s_ex,
    output logic       load_ex,
    output logic       rf_ex,
    output logic [3:0] alu_ex,
    output logic [3:0] rd_ex,
    output logic       valid_mem,
    output logic       size_mem,
    output logic       enable_mem,
    output logic       rw_mem,
    output logic       load_mem,
    output logic       rf_mem,
    output logic [3:0] rd_mem,
    output logic       valid_wb,
    output logic       load_wb,
    output logic       rf_wb,
    output logic [3:0] rd_wb,
    output logic [15:0] retired_o
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic       shift;
        logic [3:0] alu;
        logic       size;
        logic       enable;
        logic       rw;
        logic       load;
        logic       s;
        logic       rf;
        logic [3:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic       size;
        logic       enable;
        logic       rw;
        logic       load;
        logic       rf;
        logic [3:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic       load;
        logic       rf;
        logic [3:0] rd;
    } mem_wb_t;

    logic [STAGES:1] vld_pipe;
    id_ex_t          id_d;
    id_ex_t          ex_q;
    ex_mem_t         mem_q;
    mem_wb_t         wb_q;
    logic [15:0]     retired_q;

    // Bubbles keep rd but zero their control so they match an all-zero bundle;
    // a flush clears rd as well.
    always_comb begin
        id_d = '0;
        if (!flush_i) begin
            id_d.rd = rd_i;
            if (valid_i) begin
                id_d.shift  = shift_i;
                id_d.alu    = alu_i;
                id_d.size   = size_i;
                id_d.enable = enable_i;
                id_d.rw     = rw_i;
                id_d.load   = load_i;
                id_d.s      = s_i;
                id_d.rf     = rf_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            retired_q <= '0;
        end else if (!hold_i) begin
            vld_pipe     <= {vld_pipe[STAGES-1:1], valid_i & ~flush_i};
            ex_q         <= id_d;
            mem_q.size   <= ex_q.size;
            mem_q.enable <= ex_q.enable;
            mem_q.rw     <= ex_q.rw;
            mem_q.load   <= ex_q.load;
            mem_q.rf     <= ex_q.rf;
            mem_q.rd     <= ex_q.rd;
            wb_q.load    <= mem_q.load;
            wb_q.rf      <= mem_q.rf;
            wb_q.rd      <= mem_q.rd;
            if (vld_pipe[STAGES] && retired_q != 16'hFFFF)
                retired_q <= retired_q + 16'd1;
        end
    end

    assign valid_ex   = vld_pipe[1];
    assign shift_ex   = ex_q.shift & vld_pipe[1];
    assign s_ex       = ex_q.s & vld_pipe[1];
    assign load_ex    = ex_q.load & vld_pipe[1];
    assign rf_ex      = ex_q.rf & vld_pipe[1];
    assign alu_ex     = ex_q.alu & {4{vld_pipe[1]}};
    assign rd_ex      = ex_q.rd;

    assign valid_mem  = vld_pipe[2];
    assign size_mem   = mem_q.size & vld_pipe[2];
    assign enable_mem = mem_q.enable & vld_pipe[2];
    assign rw_mem     = mem_q.rw & vld_pipe[2];
    assign load_mem   = mem_q.load & vld_pipe[2];
    assign rf_mem     = mem_q.rf & vld_pipe[2];
    assign rd_mem     = mem_q.rd;

    assign valid_wb   = vld_pipe[3];
    assign load_wb    = wb_q.load & vld_pipe[3];
    assign rf_wb      = wb_q.rf & vld_pipe[3];
    assign rd_wb      = wb_q.rd;

    assign retired_o  = retired_q;
endmodule
